// File: rtl/keypad_pkg.sv
// Shared types and the key layout for the matrix keypad entry path.
// Matrix bit / keymap index is {row, col}; a set bit means that key is pressed.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    REL_DB
  } state_t;

  typedef struct packed {
    logic       none;
    logic       single;
    logic       multi;
    logic [3:0] code;
  } scan_result_t;

  // Element [15] first: row3 = E(*) 0 F(#) D, row0 = 1 2 3 A.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

endpackage

// File: rtl/ffd.sv
// Generic enable flip-flop with synchronous active-high reset to zero.
module ffd #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/keypad_keymap.sv
// Classifies one captured 4x4 scan as none / single / multi and decodes the
// single pressed key to its hex code.
module keypad_keymap
  import keypad_pkg::*;
(
  input  logic [15:0]  i_matrix,
  output scan_result_t o_result
);

  logic [4:0] w_count;
  logic [3:0] w_code;

  always_comb begin
    w_count  = '0;
    w_code   = '0;
    o_result = '0;
    for (int i = 0; i < 16; i++) begin
      if (i_matrix[i]) begin
        w_count = w_count + 5'd1;
        w_code  = KEYMAP[i];
      end
    end
    o_result.none   = (w_count == 5'd0);
    o_result.single = (w_count == 5'd1);
    o_result.multi  = (w_count >  5'd1);
    o_result.code   = w_code;
  end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner with press/release debounce; accepted keys shift
// into a 32-bit entry register that can drive the hex display directly.
//
// state    | meaning
// IDLE     | no key held, waiting for a single-key scan
// PRESS_DB | same single key seen on r_cnt consecutive scans
// PRESSED  | key accepted, waiting for an empty scan
// REL_DB   | empty scans counted in r_cnt before release
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  ROWS,
  output logic [3:0]  COLS,
  input  logic        CLEAR,
  output logic [31:0] VALUE,
  output logic [3:0]  KEY,
  output logic        KEY_VALID,
  output logic        KEY_HELD
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       r_rows_meta;
  logic [3:0]       r_rows_sync;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  logic [15:0]      r_matrix;
  logic             r_scan_done;
  logic             w_div_tc;
  scan_result_t     w_res;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cand;
  logic [3:0]       w_cand_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accept;
  logic             w_release;
  logic [3:0]       r_key;
  logic             r_key_valid;
  logic             r_key_held;

  logic             w_value_en;
  logic [31:0]      w_value_d;

  assign w_div_tc = (r_div == DIV_TC);
  assign COLS     = ~(4'b0001 << r_col);

  // Rows are only ever read through the two-flop synchronizer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rows_meta <= 4'hF;
      r_rows_sync <= 4'hF;
      r_div       <= '0;
      r_col       <= '0;
      r_matrix    <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_rows_meta <= ROWS;
      r_rows_sync <= r_rows_meta;
      r_scan_done <= w_div_tc && (r_col == 2'd3);
      if (w_div_tc) begin
        r_div <= '0;
        r_col <= r_col + 2'd1;
        for (int r = 0; r < 4; r++) begin
          r_matrix[{r[1:0], r_col}] <= ~r_rows_sync[r];
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  keypad_keymap u_keymap (
    .i_matrix (r_matrix),
    .o_result (w_res)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key      <= w_cand_nxt;
        r_key_held <= 1'b1;
      end else if (w_release) begin
        r_key_held <= 1'b0;
      end
    end
  end

  // The FSM only moves on the single cycle a completed scan result is valid.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    w_cnt_inc   = r_cnt + CNT_ONE;
    if (r_scan_done) begin
      case (r_state)
        IDLE: begin
          if (w_res.single) begin
            w_cand_nxt = w_res.code;
            if (CNT_TC == CNT_ONE) begin
              w_state_nxt = PRESSED;
              w_cnt_nxt   = '0;
              w_accept    = 1'b1;
            end else begin
              w_state_nxt = PRESS_DB;
              w_cnt_nxt   = CNT_ONE;
            end
          end
        end
        PRESS_DB: begin
          if (w_res.none || w_res.multi) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (w_res.code != r_cand) begin
            w_cand_nxt = w_res.code;
            w_cnt_nxt  = CNT_ONE;
          end else if (w_cnt_inc >= CNT_TC) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
            w_accept    = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        PRESSED: begin
          if (w_res.none) begin
            if (CNT_TC == CNT_ONE) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
              w_release   = 1'b1;
            end else begin
              w_state_nxt = REL_DB;
              w_cnt_nxt   = CNT_ONE;
            end
          end
        end
        REL_DB: begin
          if (!w_res.none) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc >= CNT_TC) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_release   = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A clear that lands on an accept keeps only the new nibble.
  assign w_value_en = w_accept || CLEAR;
  assign w_value_d  = CLEAR ? (w_accept ? {28'h0, w_cand_nxt} : 32'h0)
                            : {VALUE[27:0], w_cand_nxt};

  ffd #(32) u_value (
    .CLK   (CLK),
    .RESET (RESET),
    .i_en  (w_value_en),
    .i_d   (w_value_d),
    .o_q   (VALUE)
  );

  assign KEY       = r_key;
  assign KEY_VALID = r_key_valid;
  assign KEY_HELD  = r_key_held;

endmodule
